// File: rtl/axis_if.sv
// rtl/axis_if.sv - AXI-Stream style handshake bundle used by the pattern source
interface axis_if #(
  parameter int DATAW = 64
);
  logic [DATAW-1:0] data;
  logic             vld;
  logic             last;
  logic             rdy;

  modport out (output data, output vld, output last, input rdy);
  modport in  (input data, input vld, input last, output rdy);
endinterface

// File: rtl/axis_pattern_gen.sv
// rtl/axis_pattern_gen.sv - framed AXI-Stream test-pattern source (LFSR/counter/constant/walking-one)
module axis_pattern_gen #(
  parameter int          DATAW   = 64,
  parameter int          MAX_LEN = 1024,
  parameter logic [63:0] SEED    = 64'hFEDCBA9876543210,
  localparam int         LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             s_rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       cfg_mode,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [15:0]      cfg_frames,
  input  logic [7:0]       cfg_gap,
  input  logic [DATAW-1:0] cfg_const,
  output logic             busy,
  output logic             done,
  output logic [15:0]      frame_cnt,
  axis_if.out              m_axis
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_LEN   = LEN_W'(1);

  state_t           state;
  logic [1:0]       mode_r;
  logic [LEN_W-1:0] len_r;
  logic [15:0]      frames_r;
  logic [7:0]       gap_r;
  logic [DATAW-1:0] const_r;
  logic [LEN_W-1:0] beat_cnt;
  logic [7:0]       gap_cnt;
  logic             stop_pend;
  logic [63:0]      lfsr;
  logic [DATAW-1:0] cnt;
  logic [DATAW-1:0] walk;
  logic [DATAW-1:0] data_r;
  logic             vld_r;
  logic             last_r;

  logic [LEN_W-1:0] len_eff;
  logic [63:0]      lfsr_nxt;
  logic [DATAW-1:0] cnt_nxt;
  logic [DATAW-1:0] walk_nxt;
  logic [LEN_W:0]   beat_plus2;
  logic             beat;
  logic             frames_hit;

  assign m_axis.data = data_r;
  assign m_axis.vld  = vld_r;
  assign m_axis.last = last_r;

  function automatic logic [DATAW-1:0] pick(input logic [1:0] m, input logic [DATAW-1:0] l,
                                            input logic [DATAW-1:0] c, input logic [DATAW-1:0] k,
                                            input logic [DATAW-1:0] w);
    case (m)
      2'd0:    return l;
      2'd1:    return c;
      2'd2:    return k;
      default: return w;
    endcase
  endfunction

  always_comb begin
    len_eff = cfg_len;
    if (cfg_len == '0)
      len_eff = ONE_LEN;
    else if (cfg_len > MAX_LEN_V)
      len_eff = MAX_LEN_V;
  end

  assign lfsr_nxt   = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
  assign cnt_nxt    = cnt + DATAW'(1);
  assign walk_nxt   = {walk[DATAW-2:0], walk[DATAW-1]};
  assign beat       = vld_r && m_axis.rdy;
  // last must be set when presenting index len-1, i.e. one beat ahead of it
  assign beat_plus2 = {1'b0, beat_cnt} + (LEN_W+1)'(2);
  assign frames_hit = (frames_r != 16'd0) && ((frame_cnt + 16'd1) == frames_r);

  always_ff @(posedge clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state     <= IDLE;
      mode_r    <= 2'd0;
      len_r     <= ONE_LEN;
      frames_r  <= 16'd0;
      gap_r     <= 8'd0;
      const_r   <= '0;
      beat_cnt  <= '0;
      gap_cnt   <= 8'd0;
      stop_pend <= 1'b0;
      lfsr      <= SEED;
      cnt       <= '0;
      walk      <= DATAW'(1);
      data_r    <= '0;
      vld_r     <= 1'b0;
      last_r    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= 16'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_r    <= cfg_mode;
            len_r     <= len_eff;
            frames_r  <= cfg_frames;
            gap_r     <= cfg_gap;
            const_r   <= cfg_const;
            lfsr      <= SEED;
            cnt       <= '0;
            walk      <= DATAW'(1);
            data_r    <= pick(cfg_mode, SEED[DATAW-1:0], '0, cfg_const, DATAW'(1));
            beat_cnt  <= '0;
            frame_cnt <= 16'd0;
            stop_pend <= 1'b0;
            vld_r     <= 1'b1;
            last_r    <= (len_eff == ONE_LEN);
            busy      <= 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (stop)
            stop_pend <= 1'b1;
          if (beat) begin
            lfsr   <= lfsr_nxt;
            cnt    <= cnt_nxt;
            walk   <= walk_nxt;
            data_r <= pick(mode_r, lfsr_nxt[DATAW-1:0], cnt_nxt, const_r, walk_nxt);
            if (last_r) begin
              beat_cnt  <= '0;
              frame_cnt <= frame_cnt + 16'd1;
              if (frames_hit || stop_pend || stop) begin
                state  <= IDLE;
                vld_r  <= 1'b0;
                last_r <= 1'b0;
                busy   <= 1'b0;
                done   <= 1'b1;
              end else if (gap_r != 8'd0) begin
                state   <= GAP;
                gap_cnt <= gap_r;
                vld_r   <= 1'b0;
                last_r  <= 1'b0;
              end else begin
                last_r <= (len_r == ONE_LEN);
              end
            end else begin
              beat_cnt <= beat_cnt + ONE_LEN;
              last_r   <= (beat_plus2 == {1'b0, len_r});
            end
          end
        end
        GAP: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (gap_cnt == 8'd1) begin
            state  <= SEND;
            vld_r  <= 1'b1;
            last_r <= (len_r == ONE_LEN);
          end else begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_pattern_gen.sv
// tb/tb_axis_pattern_gen.sv - scoreboard bench for axis_pattern_gen
module tb_axis_pattern_gen;
  localparam int DATAW   = 8;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic             clk = 1'b0;
  logic             s_rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [1:0]       cfg_mode = 2'd0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [15:0]      cfg_frames = 16'd0;
  logic [7:0]       cfg_gap = 8'd0;
  logic [DATAW-1:0] cfg_const = '0;
  logic             busy;
  logic             done;
  logic [15:0]      frame_cnt;

  axis_if #(.DATAW(DATAW)) ax ();

  axis_pattern_gen #(.DATAW(DATAW), .MAX_LEN(MAX_LEN), .SEED(64'hFEDCBA9876543210)) dut (
    .clk(clk), .s_rst_n(s_rst_n), .start(start), .stop(stop),
    .cfg_mode(cfg_mode), .cfg_len(cfg_len), .cfg_frames(cfg_frames), .cfg_gap(cfg_gap),
    .cfg_const(cfg_const), .busy(busy), .done(done), .frame_cnt(frame_cnt), .m_axis(ax)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATAW-1:0] data;
    logic             last;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   beats_seen = 0;
  logic rdy_toggle = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [DATAW-1:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: pops the scoreboard on every beat and checks stall stability
  initial begin
    exp_t             e;
    logic [DATAW-1:0] pd;
    logic             pl, pv, pr;
    pd = '0; pl = 1'b0; pv = 1'b0; pr = 1'b0;
    forever begin
      @(negedge clk);
      if (pv && !pr && s_rst_n) begin
        check("hold_vld", ax.vld, 1);
        if (ax.vld) begin
          check("hold_data", ax.data, pd);
          check("hold_last", ax.last, pl);
        end
      end
      if (ax.vld && ax.rdy) begin
        beats_seen++;
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got data %0h, expected no beat", ax.data);
        end else begin
          e = q.pop_front();
          check("beat_data", ax.data, e.data);
          check("beat_last", ax.last, e.last);
        end
      end
      pv = ax.vld; pr = ax.rdy; pd = ax.data; pl = ax.last;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_toggle) ax.rdy = ~ax.rdy;
    end
  end

  task automatic run(input logic [1:0] m, input int len, input int fr, input int gap,
                     input logic [DATAW-1:0] k);
    tick();
    cfg_mode = m; cfg_len = LEN_W'(len); cfg_frames = 16'(fr); cfg_gap = 8'(gap); cfg_const = k;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_latency_vld", ax.vld, 1);
    check("start_busy", busy, 1);
  endtask

  task automatic wait_done(input int exp_frames);
    int n;
    n = 0;
    while (n < 400 && !done) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done, expected done within 400 cycles");
    end else begin
      check("done_frame_cnt", frame_cnt, 64'(exp_frames));
      check("done_busy", busy, 0);
      check("done_vld", ax.vld, 0);
      @(negedge clk);
      check("done_pulse_width", done, 0);
      check("scoreboard_drained", 64'(q.size()), 0);
    end
  endtask

  initial begin
    int               n;
    int               base;
    logic [DATAW-1:0] w;
    ax.rdy = 1'b0;
    #1;
    check("rst_vld", ax.vld, 0);
    check("rst_last", ax.last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_data", ax.data, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    repeat (3) tick();
    s_rst_n = 1'b1;

    // counter, 2 back-to-back frames of 4
    ax.rdy = 1'b1;
    for (int i = 0; i < 8; i++) push(DATAW'(i), (i % 4) == 3);
    run(2'd1, 4, 2, 0, 8'h00);
    wait_done(2);

    // LFSR with stalls: low byte of SEED, then <<1 twice (feedback bit is 0 both times)
    rdy_toggle = 1'b1;
    push(8'h10, 1'b0); push(8'h20, 1'b0); push(8'h40, 1'b1);
    run(2'd0, 3, 1, 0, 8'h00);
    wait_done(1);
    rdy_toggle = 1'b0;
    tick();
    ax.rdy = 1'b1;

    // walking one, len 10, gap 3, pattern persists into frame 2
    w = 8'h01;
    for (int i = 0; i < 20; i++) begin
      push(w, (i % 10) == 9);
      w = {w[6:0], w[7]};
    end
    run(2'd3, 10, 2, 3, 8'h00);
    n = 0;
    while (n < 100 && !(ax.vld && ax.rdy && ax.last)) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    @(negedge clk);
    while (n < 20 && !ax.vld) begin
      n++;
      @(negedge clk);
    end
    check("gap_cycles", 64'(n), 3);
    wait_done(2);

    // endless run, stop mid frame 3
    for (int i = 0; i < 15; i++) push(DATAW'(i), (i % 5) == 4);
    base = beats_seen;
    run(2'd1, 5, 0, 0, 8'h00);
    n = 0;
    while (n < 100 && beats_seen < base + 11) begin
      @(negedge clk);
      n++;
    end
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_done(3);

    // async reset mid-frame while stalled, then restart from seed
    ax.rdy = 1'b0;
    run(2'd1, 8, 1, 0, 8'h00);
    repeat (3) tick();
    #2;
    s_rst_n = 1'b0;
    #1;
    check("arst_vld", ax.vld, 0);
    check("arst_last", ax.last, 0);
    check("arst_busy", busy, 0);
    check("arst_frame_cnt", frame_cnt, 0);
    repeat (2) tick();
    s_rst_n = 1'b1;
    ax.rdy = 1'b1;
    push(8'h10, 1'b0); push(8'h20, 1'b0); push(8'h40, 1'b1);
    run(2'd0, 3, 1, 0, 8'h00);
    wait_done(1);

    // cfg_len 0 -> single-beat frames, start during run ignored
    for (int i = 0; i < 3; i++) push(8'hA5, 1'b1);
    run(2'd2, 0, 3, 2, 8'hA5);
    tick();
    cfg_mode = 2'd1; cfg_len = LEN_W'(4); cfg_frames = 16'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(3);

    // over-long length clamps to MAX_LEN
    for (int i = 0; i < MAX_LEN; i++) push(DATAW'(i), i == MAX_LEN - 1);
    run(2'd1, 31, 1, 0, 8'h00);
    wait_done(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
